// File: rtl/debug_ram_loader_pkg.sv
// Shared types and encodings for the UART-driven BRAM loader.
package debug_loader_pkg;

  localparam int unsigned WORDS_DEFAULT = 4096;
  localparam logic [7:0]  ACK_DEFAULT   = 8'hA5;
  localparam logic [7:0]  ERR_DEFAULT   = 8'hEE;

  localparam logic [7:0] CMD_LOAD_D = 8'h00;
  localparam logic [7:0] CMD_LOAD_I = 8'h01;
  localparam logic [7:0] CMD_DUMP_D = 8'h02;
  localparam logic [7:0] CMD_DUMP_I = 8'h03;
  localparam logic [7:0] CMD_RUN    = 8'h04;

  typedef enum logic [3:0] {
    IDLE,
    CNT_LO,
    CNT_HI,
    LD_BYTE,
    LD_WRITE,
    ACK,
    ERR,
    DP_ADDR,
    DP_WAIT,
    DP_SEND
  } loaderState_e;

endpackage

// File: rtl/debug_ram_loader_if.sv
// Byte streams plus both BRAM debug ports; master is the loader side.
interface debug_ram_loader_if;
  logic [7:0]  RX_Data;
  logic        RX_Valid;
  logic        RX_Ready;
  logic [7:0]  TX_Data;
  logic        TX_Valid;
  logic        TX_Ready;
  logic [31:0] CPU_Debug_DataRAM_A2;
  logic [31:0] CPU_Debug_DataRAM_WD2;
  logic [3:0]  CPU_Debug_DataRAM_WE2;
  logic [31:0] CPU_Debug_DataRAM_RD2;
  logic [31:0] CPU_Debug_InstRAM_A2;
  logic [31:0] CPU_Debug_InstRAM_WD2;
  logic [3:0]  CPU_Debug_InstRAM_WE2;
  logic [31:0] CPU_Debug_InstRAM_RD2;

  modport master (
    input  RX_Data, RX_Valid, TX_Ready,
    input  CPU_Debug_DataRAM_RD2, CPU_Debug_InstRAM_RD2,
    output RX_Ready, TX_Data, TX_Valid,
    output CPU_Debug_DataRAM_A2, CPU_Debug_DataRAM_WD2, CPU_Debug_DataRAM_WE2,
    output CPU_Debug_InstRAM_A2, CPU_Debug_InstRAM_WD2, CPU_Debug_InstRAM_WE2
  );

  modport slave (
    output RX_Data, RX_Valid, TX_Ready,
    output CPU_Debug_DataRAM_RD2, CPU_Debug_InstRAM_RD2,
    input  RX_Ready, TX_Data, TX_Valid,
    input  CPU_Debug_DataRAM_A2, CPU_Debug_DataRAM_WD2, CPU_Debug_DataRAM_WE2,
    input  CPU_Debug_InstRAM_A2, CPU_Debug_InstRAM_WD2, CPU_Debug_InstRAM_WE2
  );
endinterface

// File: rtl/debug_tx_serializer.sv
// Emits a loaded word (4 bytes, LSB first) or a single byte on a valid/ready stream.
// done pulses for one cycle after the final byte has been accepted.
module debug_tx_serializer (
  input  logic        CPU_CLK,
  input  logic        CPU_RST_N,
  input  logic        load,
  input  logic        single,
  input  logic [31:0] word,
  input  logic        txReady,
  output logic [7:0]  txData,
  output logic        txValid,
  output logic        done
);
  logic [23:0] rest;
  logic [1:0]  left;

  always_ff @(posedge CPU_CLK or negedge CPU_RST_N) begin
    if (!CPU_RST_N) begin
      txData  <= '0;
      txValid <= 1'b0;
      done    <= 1'b0;
      rest    <= '0;
      left    <= '0;
    end else begin
      done <= 1'b0;
      if (load) begin
        txData  <= word[7:0];
        rest    <= word[31:8];
        left    <= single ? 2'd0 : 2'd3;
        txValid <= 1'b1;
      end else if (txValid && txReady) begin
        if (left == 2'd0) begin
          txValid <= 1'b0;
          done    <= 1'b1;
        end else begin
          txData <= rest[7:0];
          rest   <= {8'h00, rest[23:8]};
          left   <= left - 2'd1;
        end
      end
    end
  end
endmodule

// File: rtl/debug_ram_loader.sv
// Command-driven BRAM preload/dump through the core debug ports; holds the core
// in reset until RUN.
module debug_ram_loader
  import debug_loader_pkg::*;
#(
  parameter int unsigned WORDS    = WORDS_DEFAULT,
  parameter logic [7:0]  ACK_BYTE = ACK_DEFAULT,
  parameter logic [7:0]  ERR_BYTE = ERR_DEFAULT
) (
  input  logic               CPU_CLK,
  input  logic               CPU_RST_N,
  debug_ram_loader_if.master bus,
  output logic               Core_Rst,
  output logic               Busy
);
  localparam int unsigned IDX_W = $clog2(WORDS);
  localparam int unsigned CNT_W = 16;

  loaderState_e     state, stateNext;
  logic [7:0]       cntLo, cntLoNext;
  logic [CNT_W-1:0] remaining, remainingNext;
  logic [IDX_W-1:0] idx, idxNext, idxInc;
  logic [1:0]       byteCnt, byteCntNext;
  logic [23:0]      partial, partialNext;
  logic             selInst, selInstNext, isDump, isDumpNext;
  logic             coreRstNext, rxReady, rxReadyNext, busyNext, rxFire;
  logic [31:0]      dA2, dA2Next, dWD2, dWD2Next, iA2, iA2Next, iWD2, iWD2Next;
  logic [3:0]       dWE2, dWE2Next, iWE2, iWE2Next;
  logic [CNT_W-1:0] countRaw, countEff;
  logic             serLoad, serSingle, serDone;
  logic [31:0]      serWord;

  assign rxFire   = bus.RX_Valid & rxReady;
  assign countRaw = {bus.RX_Data, cntLo};
  assign countEff = (32'(countRaw) > WORDS) ? CNT_W'(WORDS) : countRaw;
  assign idxInc   = idx + IDX_W'(1);

  assign bus.RX_Ready              = rxReady;
  assign bus.CPU_Debug_DataRAM_A2  = dA2;
  assign bus.CPU_Debug_DataRAM_WD2 = dWD2;
  assign bus.CPU_Debug_DataRAM_WE2 = dWE2;
  assign bus.CPU_Debug_InstRAM_A2  = iA2;
  assign bus.CPU_Debug_InstRAM_WD2 = iWD2;
  assign bus.CPU_Debug_InstRAM_WE2 = iWE2;

  debug_tx_serializer u_tx (
    .CPU_CLK  (CPU_CLK),
    .CPU_RST_N(CPU_RST_N),
    .load     (serLoad),
    .single   (serSingle),
    .word     (serWord),
    .txReady  (bus.TX_Ready),
    .txData   (bus.TX_Data),
    .txValid  (bus.TX_Valid),
    .done     (serDone)
  );

  always_ff @(posedge CPU_CLK or negedge CPU_RST_N) begin
    if (!CPU_RST_N) begin
      state     <= IDLE;
      cntLo     <= '0;
      remaining <= '0;
      idx       <= '0;
      byteCnt   <= '0;
      partial   <= '0;
      selInst   <= 1'b0;
      isDump    <= 1'b0;
      Core_Rst  <= 1'b1;
      Busy      <= 1'b0;
      rxReady   <= 1'b1;
      dA2       <= '0;
      dWD2      <= '0;
      dWE2      <= '0;
      iA2       <= '0;
      iWD2      <= '0;
      iWE2      <= '0;
    end else begin
      state     <= stateNext;
      cntLo     <= cntLoNext;
      remaining <= remainingNext;
      idx       <= idxNext;
      byteCnt   <= byteCntNext;
      partial   <= partialNext;
      selInst   <= selInstNext;
      isDump    <= isDumpNext;
      Core_Rst  <= coreRstNext;
      Busy      <= busyNext;
      rxReady   <= rxReadyNext;
      dA2       <= dA2Next;
      dWD2      <= dWD2Next;
      dWE2      <= dWE2Next;
      iA2       <= iA2Next;
      iWD2      <= iWD2Next;
      iWE2      <= iWE2Next;
    end
  end

  always_comb begin
    stateNext     = state;
    cntLoNext     = cntLo;
    remainingNext = remaining;
    idxNext       = idx;
    byteCntNext   = byteCnt;
    partialNext   = partial;
    selInstNext   = selInst;
    isDumpNext    = isDump;
    coreRstNext   = Core_Rst;
    dA2Next       = dA2;
    dWD2Next      = dWD2;
    dWE2Next      = '0;
    iA2Next       = iA2;
    iWD2Next      = iWD2;
    iWE2Next      = '0;
    serLoad       = 1'b0;
    serSingle     = 1'b0;
    serWord       = '0;

    unique case (state)
      IDLE: if (rxFire) begin
        case (bus.RX_Data)
          CMD_LOAD_D, CMD_LOAD_I, CMD_DUMP_D, CMD_DUMP_I: begin
            selInstNext = bus.RX_Data[0];
            isDumpNext  = bus.RX_Data[1];
            coreRstNext = 1'b1;
            stateNext   = CNT_LO;
          end
          CMD_RUN: begin
            coreRstNext = 1'b0;
            serLoad     = 1'b1;
            serSingle   = 1'b1;
            serWord     = {24'h0, ACK_BYTE};
            stateNext   = ACK;
          end
          default: begin
            serLoad   = 1'b1;
            serSingle = 1'b1;
            serWord   = {24'h0, ERR_BYTE};
            stateNext = ERR;
          end
        endcase
      end
      CNT_LO: if (rxFire) begin
        cntLoNext = bus.RX_Data;
        stateNext = CNT_HI;
      end
      CNT_HI: if (rxFire) begin
        remainingNext = countEff;
        idxNext       = '0;
        byteCntNext   = '0;
        if (countEff == '0) begin
          if (isDump) begin
            stateNext = IDLE;
          end else begin
            serLoad   = 1'b1;
            serSingle = 1'b1;
            serWord   = {24'h0, ACK_BYTE};
            stateNext = ACK;
          end
        end else if (isDump) begin
          if (selInst) iA2Next = '0;
          else         dA2Next = '0;
          stateNext = DP_ADDR;
        end else begin
          stateNext = LD_BYTE;
        end
      end
      // Bytes shift in from the top so the first byte ends up in bits [7:0].
      LD_BYTE: if (rxFire) begin
        byteCntNext = byteCnt + 2'd1;
        partialNext = {bus.RX_Data, partial[23:8]};
        if (byteCnt == 2'd3) begin
          stateNext = LD_WRITE;
          if (selInst) begin
            iA2Next  = 32'({idx, 2'b00});
            iWD2Next = {bus.RX_Data, partial};
            iWE2Next = 4'hF;
          end else begin
            dA2Next  = 32'({idx, 2'b00});
            dWD2Next = {bus.RX_Data, partial};
            dWE2Next = 4'hF;
          end
        end
      end
      LD_WRITE: begin
        if (remaining == CNT_W'(1)) begin
          serLoad   = 1'b1;
          serSingle = 1'b1;
          serWord   = {24'h0, ACK_BYTE};
          stateNext = ACK;
        end else begin
          remainingNext = remaining - CNT_W'(1);
          idxNext       = idxInc;
          stateNext     = LD_BYTE;
        end
      end
      ACK, ERR: if (serDone) stateNext = IDLE;
      DP_ADDR: stateNext = DP_WAIT;
      DP_WAIT: begin
        serLoad   = 1'b1;
        serWord   = selInst ? bus.CPU_Debug_InstRAM_RD2 : bus.CPU_Debug_DataRAM_RD2;
        stateNext = DP_SEND;
      end
      DP_SEND: if (serDone) begin
        if (remaining == CNT_W'(1)) begin
          stateNext = IDLE;
        end else begin
          remainingNext = remaining - CNT_W'(1);
          idxNext       = idxInc;
          if (selInst) iA2Next = 32'({idxInc, 2'b00});
          else         dA2Next = 32'({idxInc, 2'b00});
          stateNext = DP_ADDR;
        end
      end
      default: stateNext = IDLE;
    endcase

    rxReadyNext = (stateNext == IDLE) || (stateNext == CNT_LO) ||
                  (stateNext == CNT_HI) || (stateNext == LD_BYTE);
    busyNext    = (stateNext != IDLE);
  end
endmodule

// File: tb/tb_debug_ram_loader.sv
// Table-driven command transactions plus hand-written timing/reset sequences
// against a BRAM model on both debug ports.
module tb_debug_ram_loader;
  import debug_loader_pkg::*;

  logic CPU_CLK = 1'b0;
  logic CPU_RST_N = 1'b0;
  logic Core_Rst, Busy;
  logic [7:0] rxData = 8'h00;
  logic rxValid = 1'b0;
  logic txReady = 1'b1;
  bit   toggle = 1'b0;

  debug_ram_loader_if bus();
  assign bus.RX_Data  = rxData;
  assign bus.RX_Valid = rxValid;
  assign bus.TX_Ready = txReady;

  debug_ram_loader dut (
    .CPU_CLK  (CPU_CLK),
    .CPU_RST_N(CPU_RST_N),
    .bus      (bus),
    .Core_Rst (Core_Rst),
    .Busy     (Busy)
  );

  always #5 CPU_CLK = ~CPU_CLK;

  int errors = 0;
  int checks = 0;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Synchronous-read BRAM models, one cycle read latency.
  logic [31:0] dMem [4096];
  logic [31:0] iMem [4096];
  always @(posedge CPU_CLK) begin
    for (int b = 0; b < 4; b++) begin
      if (bus.CPU_Debug_DataRAM_WE2[b])
        dMem[bus.CPU_Debug_DataRAM_A2[13:2]][8*b +: 8] <= bus.CPU_Debug_DataRAM_WD2[8*b +: 8];
      if (bus.CPU_Debug_InstRAM_WE2[b])
        iMem[bus.CPU_Debug_InstRAM_A2[13:2]][8*b +: 8] <= bus.CPU_Debug_InstRAM_WD2[8*b +: 8];
    end
    bus.CPU_Debug_DataRAM_RD2 <= dMem[bus.CPU_Debug_DataRAM_A2[13:2]];
    bus.CPU_Debug_InstRAM_RD2 <= iMem[bus.CPU_Debug_InstRAM_A2[13:2]];
  end

  always @(posedge CPU_CLK) begin
    #1;
    txReady = toggle ? ~txReady : 1'b1;
  end

  typedef struct {
    bit          inst;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  we;
  } wr_t;

  wr_t        wrQ[$];
  logic [7:0] txQ[$];
  logic       prevStall = 1'b0;
  logic [7:0] prevData = 8'h00;

  // Records writes and TX transfers; checks TX data holds while stalled.
  always @(negedge CPU_CLK) begin
    wr_t w;
    if (CPU_RST_N) begin
      if (prevStall)
        check32("tx_hold", {23'h0, bus.TX_Valid, bus.TX_Data}, {23'h0, 1'b1, prevData});
      if (bus.TX_Valid && txReady) txQ.push_back(bus.TX_Data);
      if (bus.CPU_Debug_DataRAM_WE2 != 4'h0) begin
        w.inst = 1'b0; w.addr = bus.CPU_Debug_DataRAM_A2;
        w.data = bus.CPU_Debug_DataRAM_WD2; w.we = bus.CPU_Debug_DataRAM_WE2;
        wrQ.push_back(w);
      end
      if (bus.CPU_Debug_InstRAM_WE2 != 4'h0) begin
        w.inst = 1'b1; w.addr = bus.CPU_Debug_InstRAM_A2;
        w.data = bus.CPU_Debug_InstRAM_WD2; w.we = bus.CPU_Debug_InstRAM_WE2;
        wrQ.push_back(w);
      end
      prevStall = bus.TX_Valid && !txReady;
      prevData  = bus.TX_Data;
    end else begin
      prevStall = 1'b0;
    end
  end

  // Called at posedge+1; returns at posedge+1 after the byte was accepted.
  task automatic sendByte(input logic [7:0] b);
    int  t = 0;
    logic acc = 1'b0;
    rxData  = b;
    rxValid = 1'b1;
    while (!acc && t < 1000) begin
      @(negedge CPU_CLK);
      acc = bus.RX_Ready;
      @(posedge CPU_CLK);
      #1;
      t++;
    end
    rxValid = 1'b0;
    if (!acc) check32("rx_accept_timeout", 32'(acc), 32'd1);
  endtask

  task automatic waitIdle(input string name);
    int   t = 0;
    logic idle = 1'b0;
    while (!idle && t < 2000) begin
      @(negedge CPU_CLK);
      idle = !Busy;
      t++;
    end
    @(posedge CPU_CLK);
    #1;
    check32(name, 32'(idle), 32'd1);
  endtask

  typedef struct {
    logic [7:0]  cmd;
    logic [15:0] n;
    logic [31:0] w0;
    logic [31:0] w1;
    bit          tog;
    int          nWr;
    int          nTx;
    logic [63:0] tx;
    logic        coreRst;
  } vec_t;

  localparam int NV = 14;
  vec_t vec[NV];

  initial begin
    vec[0]  = '{8'h00, 16'd2, 32'h12345678, 32'hDEADBEEF, 1'b0, 2, 1, 64'hA5, 1'b1};
    vec[1]  = '{8'h01, 16'd2, 32'h00000013, 32'h00100093, 1'b0, 2, 1, 64'hA5, 1'b1};
    vec[2]  = '{8'h03, 16'd2, 32'h0, 32'h0, 1'b1, 0, 8, 64'h00100093_00000013, 1'b1};
    vec[3]  = '{8'h02, 16'd2, 32'h0, 32'h0, 1'b1, 0, 8, 64'hDEADBEEF_12345678, 1'b1};
    vec[4]  = '{8'h04, 16'd0, 32'h0, 32'h0, 1'b0, 0, 1, 64'hA5, 1'b0};
    vec[5]  = '{8'h7F, 16'd0, 32'h0, 32'h0, 1'b0, 0, 1, 64'hEE, 1'b0};
    vec[6]  = '{8'h00, 16'd0, 32'h0, 32'h0, 1'b0, 0, 1, 64'hA5, 1'b1};
    vec[7]  = '{8'h04, 16'd0, 32'h0, 32'h0, 1'b0, 0, 1, 64'hA5, 1'b0};
    vec[8]  = '{8'h02, 16'd0, 32'h0, 32'h0, 1'b0, 0, 0, 64'h0, 1'b1};
    vec[9]  = '{8'h04, 16'd0, 32'h0, 32'h0, 1'b0, 0, 1, 64'hA5, 1'b0};
    vec[10] = '{8'h02, 16'd1, 32'h0, 32'h0, 1'b0, 0, 4, 64'h12345678, 1'b1};
    vec[11] = '{8'h7F, 16'd0, 32'h0, 32'h0, 1'b0, 0, 1, 64'hEE, 1'b1};
    vec[12] = '{8'h05, 16'd0, 32'h0, 32'h0, 1'b0, 0, 1, 64'hEE, 1'b1};
    vec[13] = '{8'hFF, 16'd0, 32'h0, 32'h0, 1'b0, 0, 1, 64'hEE, 1'b1};

    // Reset values
    repeat (3) @(posedge CPU_CLK);
    #1;
    check32("rst_core_busy_rdy", {29'h0, Core_Rst, Busy, bus.RX_Ready}, 32'b101);
    check32("rst_tx", {23'h0, bus.TX_Valid, bus.TX_Data}, 32'h0);
    check32("rst_we2", {24'h0, bus.CPU_Debug_DataRAM_WE2, bus.CPU_Debug_InstRAM_WE2}, 32'h0);
    check32("rst_a2_or_wd2", bus.CPU_Debug_DataRAM_A2 | bus.CPU_Debug_DataRAM_WD2 |
            bus.CPU_Debug_InstRAM_A2 | bus.CPU_Debug_InstRAM_WD2, 32'h0);
    @(negedge CPU_CLK);
    CPU_RST_N = 1'b1;
    @(posedge CPU_CLK);
    #1;

    for (int v = 0; v < NV; v++) begin
      int nw;
      logic [31:0] w;
      wrQ.delete();
      txQ.delete();
      toggle = vec[v].tog;
      sendByte(vec[v].cmd);
      if (vec[v].cmd <= 8'h03) begin
        sendByte(vec[v].n[7:0]);
        sendByte(vec[v].n[15:8]);
        if (!vec[v].cmd[1]) begin
          nw = (vec[v].n > 16'd2) ? 2 : int'(vec[v].n);
          for (int i = 0; i < nw; i++) begin
            w = (i == 0) ? vec[v].w0 : vec[v].w1;
            for (int b = 0; b < 4; b++) sendByte(w[8*b +: 8]);
          end
        end
      end
      waitIdle($sformatf("v%0d_idle", v));
      toggle = 1'b0;
      check32($sformatf("v%0d_nwr", v), 32'(wrQ.size()), 32'(vec[v].nWr));
      for (int i = 0; i < wrQ.size() && i < vec[v].nWr; i++) begin
        check32($sformatf("v%0d_wr%0d_addr", v, i), wrQ[i].addr, 32'(4 * i));
        check32($sformatf("v%0d_wr%0d_data", v, i), wrQ[i].data, (i == 0) ? vec[v].w0 : vec[v].w1);
        check32($sformatf("v%0d_wr%0d_ram_we", v, i), {27'h0, wrQ[i].inst, wrQ[i].we},
                {27'h0, vec[v].cmd[0], 4'hF});
      end
      check32($sformatf("v%0d_ntx", v), 32'(txQ.size()), 32'(vec[v].nTx));
      for (int k = 0; k < txQ.size() && k < vec[v].nTx; k++)
        check32($sformatf("v%0d_tx%0d", v, k), 32'(txQ[k]), 32'(vec[v].tx[8*k +: 8]));
      check32($sformatf("v%0d_core_rst", v), 32'(Core_Rst), 32'(vec[v].coreRst));
    end

    // RUN: Core_Rst falls the cycle after acceptance, ACK appears the same cycle
    txQ.delete();
    rxData = 8'h04; rxValid = 1'b1;
    @(negedge CPU_CLK);
    check32("run_pre", {30'h0, Core_Rst, bus.RX_Ready}, 32'b11);
    @(posedge CPU_CLK); #1;
    rxValid = 1'b0;
    check32("run_core_rst_fall", 32'(Core_Rst), 32'd0);
    check32("run_tx_next_cycle", {23'h0, bus.TX_Valid, bus.TX_Data}, 32'h1A5);
    waitIdle("run_idle");
    check32("run_ntx", 32'(txQ.size()), 32'd1);
    rxData = 8'h00; rxValid = 1'b1;
    @(posedge CPU_CLK); #1;
    rxValid = 1'b0;
    check32("load_core_rst_rise", {30'h0, Core_Rst, Busy}, 32'b11);
    sendByte(8'h00); sendByte(8'h00);
    waitIdle("load0_idle");

    // LOAD write timing: WE2 exactly one cycle after the 4th byte
    wrQ.delete();
    sendByte(8'h00); sendByte(8'h01); sendByte(8'h00);
    sendByte(8'h11); sendByte(8'h22); sendByte(8'h33); sendByte(8'h44);
    check32("ldw_we_rdy", {23'h0, bus.CPU_Debug_DataRAM_WE2, bus.CPU_Debug_InstRAM_WE2, bus.RX_Ready},
            {23'h0, 4'hF, 4'h0, 1'b0});
    check32("ldw_a2", bus.CPU_Debug_DataRAM_A2, 32'h0);
    check32("ldw_wd2", bus.CPU_Debug_DataRAM_WD2, 32'h44332211);
    @(posedge CPU_CLK); #1;
    check32("ldw_we_drop", 32'(bus.CPU_Debug_DataRAM_WE2), 32'h0);
    check32("ldw_ack", {23'h0, bus.TX_Valid, bus.TX_Data}, 32'h1A5);
    waitIdle("ldw_idle");

    // DUMP latency: first TX_Valid 3 cycles after the last header byte
    txQ.delete();
    sendByte(8'h02); sendByte(8'h01); sendByte(8'h00);
    check32("dp_c1", {23'h0, bus.TX_Valid, bus.CPU_Debug_DataRAM_A2[7:0]}, 32'h0);
    @(posedge CPU_CLK); #1;
    check32("dp_c2", 32'(bus.TX_Valid), 32'd0);
    @(posedge CPU_CLK); #1;
    check32("dp_c3", {23'h0, bus.TX_Valid, bus.TX_Data}, 32'h111);
    waitIdle("dp_idle");
    check32("dp_ntx", 32'(txQ.size()), 32'd4);
    if (txQ.size() == 4) check32("dp_bytes", {txQ[3], txQ[2], txQ[1], txQ[0]}, 32'h44332211);

    // Oversized count saturates to WORDS
    wrQ.delete();
    txQ.delete();
    sendByte(8'h00); sendByte(8'hFF); sendByte(8'hFF);
    for (int k = 0; k < 4096 * 4; k++) sendByte(8'(k));
    waitIdle("big_idle");
    check32("big_nwr", 32'(wrQ.size()), 32'd4096);
    if (wrQ.size() == 4096) begin
      int bad = 0;
      for (int i = 0; i < 4096; i++) if (wrQ[i].inst || wrQ[i].addr != 32'(4 * i)) bad++;
      check32("big_addr_seq", 32'(bad), 32'd0);
      check32("big_last_addr", wrQ[4095].addr, 32'h3FFC);
      check32("big_last_data", wrQ[4095].data, 32'hFFFEFDFC);
    end
    check32("big_ntx", 32'(txQ.size()), 32'd1);
    if (txQ.size() == 1) check32("big_ack", 32'(txQ[0]), 32'hA5);

    // Reset in the middle of a word's payload
    sendByte(8'h00); sendByte(8'h02); sendByte(8'h00);
    sendByte(8'hAA); sendByte(8'hBB);
    CPU_RST_N = 1'b0;
    #1;
    check32("mid_rst_state", {28'h0, Core_Rst, Busy, bus.RX_Ready, bus.TX_Valid}, 32'b1010);
    check32("mid_rst_we", 32'(bus.CPU_Debug_DataRAM_WE2), 32'h0);
    @(negedge CPU_CLK);
    CPU_RST_N = 1'b1;
    @(posedge CPU_CLK); #1;
    wrQ.delete();
    sendByte(8'h00); sendByte(8'h01); sendByte(8'h00);
    sendByte(8'h0D); sendByte(8'hF0); sendByte(8'hFE); sendByte(8'hCA);
    waitIdle("after_rst_idle");
    check32("after_rst_nwr", 32'(wrQ.size()), 32'd1);
    if (wrQ.size() == 1) begin
      check32("after_rst_addr", wrQ[0].addr, 32'h0);
      check32("after_rst_data", wrQ[0].data, 32'hCAFEF00D);
    end

    // Reset during the write cycle kills WE2 asynchronously
    sendByte(8'h01); sendByte(8'h01); sendByte(8'h00);
    sendByte(8'h01); sendByte(8'h02); sendByte(8'h03); sendByte(8'h04);
    check32("wr_rst_pre", 32'(bus.CPU_Debug_InstRAM_WE2), 32'hF);
    #1;
    CPU_RST_N = 1'b0;
    #1;
    check32("wr_rst_we", {24'h0, bus.CPU_Debug_InstRAM_WE2, bus.CPU_Debug_DataRAM_WE2}, 32'h0);
    check32("wr_rst_a2", bus.CPU_Debug_InstRAM_A2, 32'h0);
    check32("wr_rst_state", {30'h0, Core_Rst, Busy}, 32'b10);
    @(negedge CPU_CLK);
    CPU_RST_N = 1'b1;
    repeat (2) @(posedge CPU_CLK);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d of %0d checks", errors, checks);
    $fatal(1);
  end
endmodule

// File: doc/debug_ram_loader.md
# debug_ram_loader

Synthesizable replacement for simulation-only memory preload and dump. It takes a byte command stream from an upstream UART receiver and drives the RV32Core debug ports on both BRAMs (`CPU_Debug_DataRAM_*`, `CPU_Debug_InstRAM_*`). It fills either BRAM with little-endian words, or dumps a BRAM back out as bytes on a TX stream. It holds the core in reset until it receives a RUN command.

## Interface
Parameters:
- WORDS, 4096: BRAM depth in 32-bit words; the word count saturates to this value.
- ACK_BYTE, 8'hA5: completion byte sent after LOAD and RUN.
- ERR_BYTE, 8'hEE: byte sent for an unknown command.

Ports:
- CPU_CLK  in  1  single clock.
- CPU_RST_N  in  1  asynchronous, active-low reset.
- RX_Data  in  8  command/payload byte.
- RX_Valid  in  1  RX byte present.
- RX_Ready  out  1  block accepts a byte this cycle.
- TX_Data  out  8  response byte.
- TX_Valid  out  1  TX byte present.
- TX_Ready  in  1  downstream accepts the byte.
- CPU_Debug_DataRAM_A2 / _WD2 / _WE2  out  32/32/4  data BRAM debug address, write data, byte enables.
- CPU_Debug_DataRAM_RD2  in  32  data BRAM debug read data.
- CPU_Debug_InstRAM_A2 / _WD2 / _WE2 / _RD2  as above, for the instruction BRAM.
- Core_Rst  out  1  active-high reset to RV32Core CPU_RST.
- Busy  out  1  high whenever the state is not IDLE.

## Operation
- Command byte encoding:
  - 0x00 LOAD data BRAM; 0x01 LOAD inst BRAM.
  - 0x02 DUMP data BRAM; 0x03 DUMP inst BRAM.
  - 0x04 RUN.
  - Any other value: respond ERR_BYTE and return to IDLE.
- LOAD/DUMP header: after the command, two bytes give count N (16 bit, LSB first).
  - Effective count is min(N, WORDS).
  - N=0 skips the transfer phase. LOAD still sends ACK_BYTE; DUMP sends nothing.
- Word i always uses address 4*i, i = 0..N-1.
- LOAD: each group of 4 RX bytes is packed LSB first into one word.
  - The selected `_WD2` is driven with the word and `_WE2` = 4'b1111 for exactly one cycle.
  - The other BRAM's WE2 stays 0.
  - After the last word, ACK_BYTE is sent.
  - Payload bytes beyond the effective count are treated as new commands.
- DUMP: for each word, drive A2, capture RD2 one cycle later, then emit 4 bytes LSB first.
- RUN: Core_Rst deasserts (1→0) and ACK_BYTE is sent.
- Core_Rst behaviour:
  - Reasserts on acceptance of any LOAD or DUMP command byte.
  - Held at 1 from reset until RUN.
  - Unaffected by ERR.
- States and transitions:
  - IDLE → CNT_LO → CNT_HI → LD_BYTE ⇄ LD_WRITE → ACK → IDLE.
  - CNT_HI → DP_ADDR → DP_WAIT → DP_SEND → (DP_ADDR | IDLE).
  - IDLE → ACK (RUN) or ERR (unknown command) → IDLE.
- Arithmetic: 12-bit word index, 2-bit byte counter, 16-bit remaining count. The index never wraps, because the count is capped at WORDS.

## Timing
- Reset values (asynchronous, while CPU_RST_N=0):
  - state IDLE.
  - Core_Rst=1, Busy=0, RX_Ready=1.
  - TX_Valid=0, TX_Data=0.
  - All A2/WD2/WE2 = 0.
  - Counters cleared; partial word discarded.
- Reset asserted mid-write deasserts WE2 immediately; a word already committed stays in BRAM.
- RX handshake:
  - RX_Ready is a decode of state: 1 in IDLE, CNT_LO, CNT_HI and LD_BYTE; 0 otherwise.
  - A byte transfers on a CPU_CLK edge with RX_Valid & RX_Ready.
- TX handshake:
  - TX_Valid is registered.
  - TX_Data is stable while TX_Valid & !TX_Ready.
  - One byte transfers per TX_Valid & TX_Ready cycle; no byte is dropped or repeated.
- LOAD write timing: the write is issued in the cycle after the 4th byte of a word is accepted (LD_WRITE, RX_Ready=0). Sustained throughput is one word per 5 cycles.
- DUMP read: A2 valid in DP_ADDR; RD2 sampled at the end of DP_WAIT (1-cycle BRAM latency). First TX_Valid of a word arrives 3 cycles after the header's last byte.
- ACK/ERR: TX_Valid rises the cycle after the terminating event and holds until accepted.
- Core_Rst is registered: it falls the cycle after the RUN byte is accepted and rises the cycle after a LOAD/DUMP byte is accepted.
- No simultaneous RX/TX: a byte arriving during ACK/ERR/DUMP waits, because RX_Ready=0.

## Structure
- Package debug_loader_pkg:
  - state enum.
  - CMD_LOAD_D, CMD_LOAD_I, CMD_DUMP_D, CMD_DUMP_I, CMD_RUN encodings.
  - ACK/ERR defaults.
- Sub-module debug_tx_serializer: loads a 32-bit word or a single byte and emits bytes LSB first under TX valid/ready. It reports done after the last byte is accepted.
- All FSM, counters and debug-port muxing stay in the top.

## Test plan
- Reset, then LOAD data with 00,02,00 + bytes 78 56 34 12 EF BE AD DE → Data WE2=1111 once at A2=0 with WD2=0x12345678, then at A2=4 with 0xDEADBEEF; TX=0xA5; Core_Rst stays 1.
- DUMP inst with N=2 after preloading inst[0]=0x00000013, inst[1]=0x00100093, TX_Ready toggled every other cycle → TX bytes 13 00 00 00 93 00 10 00, no duplicates.
- RUN (0x04) → Core_Rst 1→0 one cycle later, TX=0xA5; a following LOAD byte → Core_Rst back to 1.
- Command 0x7F → TX=0xEE, no WE2 activity, Core_Rst unchanged.
- LOAD with N=0xFFFF → exactly 4096 writes ending at A2=0x3FFC, then ACK; N=0 → immediate ACK, no writes.
- CPU_RST_N pulsed low after 2 payload bytes → WE2=0, state IDLE, Core_Rst=1. A new LOAD then writes its first word at A2=0.
